// File: rtl/decoder_xx6812_pkg.sv
// Shared constants and state encoding for the xx6812 one-wire LED decoder.
// The encoder side uses the same timing defaults and pixel width.
package decoder_xx6812_pkg;

  localparam int PIXEL_BITS            = 24;
  localparam int DEF_BIT_THRESHOLD     = 6;
  localparam int DEF_MIN_HIGH_CYCLES   = 2;
  localparam int DEF_MAX_HIGH_CYCLES   = 20;
  localparam int DEF_RESET_CYCLES      = 600;
  localparam int DEF_INDEX_WIDTH       = 9;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/decoder_xx6812_sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous serial line, followed by a
// registered level with matching one-cycle rise and fall pulses.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, level_q, rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      level_q <= sync_q;
      rise_q  <= sync_q & ~level_q;
      fall_q  <= ~sync_q & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/decoder_xx6812.sv
// xx6812 one-wire receiver: pulse-width bit decode, 24-bit pixel packing, frame tracking.
// Optional daisy-chain pass-through on serial_data_out when XX6812_FORWARD_EN is defined.
module decoder_xx6812
  import decoder_xx6812_pkg::*;
#(
  parameter int BIT_THRESHOLD   = DEF_BIT_THRESHOLD,
  parameter int MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES,
  parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
  parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH
) (
  input  logic                   clock_12mhz,
  input  logic                   reset_n,
  input  logic                   serial_data_in,
  output logic [PIXEL_BITS-1:0]  pixel_data,
  output logic [INDEX_WIDTH-1:0] pixel_index,
  output logic                   pixel_valid,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   serial_data_out
);

  localparam int CNT_W    = $clog2(RESET_CYCLES + 1);
  localparam int BITCNT_W = $clog2(PIXEL_BITS + 1);
  localparam logic [CNT_W:0]    MIN_LEN  = (CNT_W+1)'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W:0]    MAX_LEN  = (CNT_W+1)'(MAX_HIGH_CYCLES);
  localparam logic [CNT_W:0]    THR_LEN  = (CNT_W+1)'(BIT_THRESHOLD);
  localparam logic [CNT_W:0]    LOW_LEN  = (CNT_W+1)'(RESET_CYCLES - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(PIXEL_BITS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic level, rise, fall, edge_s;
  state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          run_len;
  logic [PIXEL_BITS-2:0]   shift_q, shift_d;
  logic [PIXEL_BITS-1:0]   word;
  logic [BITCNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic [PIXEL_BITS-1:0]   pdata_q, pdata_d;
  logic [INDEX_WIDTH-1:0]  pidx_q, pidx_d;
  logic                    pvalid_q, pvalid_d, fdone_q, fdone_d, ferr_q, ferr_d;
  logic                    bit_now, low_done, hi_err, px_done;

  sync_edge_detect u_sync (
    .clk_i   (clock_12mhz),
    .rst_ni  (reset_n),
    .d_i     (serial_data_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // run_len = cycles the current level has lasted before this cycle
  assign edge_s   = rise | fall;
  assign run_len  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign low_done = !level && (run_len >= LOW_LEN);
  assign hi_err   = (state_q == ST_HIGH) &&
                    (fall ? (run_len < MIN_LEN) : (run_len >= MAX_LEN));
  assign bit_now  = run_len >= THR_LEN;
  assign word     = {shift_q, bit_now};

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) state_q <= ST_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC: if (low_done) state_d = ST_IDLE;
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (hi_err)    state_d = ST_SYNC;
        else if (fall) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (rise)          state_d = ST_HIGH;
        else if (low_done) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    cnt_d    = (edge_s || (state_q == ST_SYNC && level)) ? '0 : sat_inc(cnt_q);
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    pdata_d  = pdata_q;
    pidx_d   = pidx_q;
    pvalid_d = 1'b0;
    fdone_d  = 1'b0;
    ferr_d   = 1'b0;
    px_done  = 1'b0;
    unique case (state_q)
      ST_HIGH: begin
        if (hi_err) begin
          ferr_d   = 1'b1;
          bitcnt_d = '0;
          idx_d    = '0;
          ovf_d    = 1'b0;
        end else if (fall) begin
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            // Pixels past the last addressable index are silently dropped.
            if (!ovf_q) begin
              px_done  = 1'b1;
              pvalid_d = 1'b1;
              pdata_d  = word;
              pidx_d   = idx_q;
              if (idx_q == '1) ovf_d = 1'b1;
              else             idx_d = idx_q + INDEX_WIDTH'(1);
            end
          end else begin
            shift_d  = word[PIXEL_BITS-2:0];
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (!rise && low_done) begin
          fdone_d  = 1'b1;
          ferr_d   = (bitcnt_q != '0) || ovf_q;
          bitcnt_d = '0;
          idx_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      pdata_q  <= '0;
      pidx_q   <= '0;
      pvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      pdata_q  <= pdata_d;
      pidx_q   <= pidx_d;
      pvalid_q <= pvalid_d;
      fdone_q  <= fdone_d;
      ferr_q   <= ferr_d;
    end
  end

  assign pixel_data  = pdata_q;
  assign pixel_index = pidx_q;
  assign pixel_valid = pvalid_q;
  assign frame_done  = fdone_q;
  assign frame_error = ferr_q;

`ifdef XX6812_FORWARD_EN
  // Armed when pixel 0 is consumed; the pass-through opens on the next rise.
  logic arm_q, arm_d, gate_q, gate_d;

  always_comb begin
    arm_d  = arm_q;
    gate_d = gate_q | (arm_q & rise);
    if (arm_q && rise)            arm_d = 1'b0;
    if (px_done && idx_q == '0)   arm_d = 1'b1;
    if (fdone_d || ferr_d) begin
      arm_d  = 1'b0;
      gate_d = 1'b0;
    end
  end

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      arm_q  <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      gate_q <= gate_d;
    end
  end

  assign serial_data_out = level & (gate_q | (arm_q & rise));
`else
  assign serial_data_out = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_xx6812.sv
// Self-checking bench for decoder_xx6812: vector table, directed corner sequences,
// and randomized frames checked against a pulse-level reference model.
module tb_decoder_xx6812;

  localparam int THR   = 6;
  localparam int MINH  = 2;
  localparam int MAXH  = 20;
  localparam int RST_C = 600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b0;
  logic [23:0] pixel_data;
  logic [8:0]  pixel_index;
  logic        pixel_valid, frame_done, frame_error, sdo;

  decoder_xx6812 dut (
    .clock_12mhz     (clk),
    .reset_n         (rst_n),
    .serial_data_in  (sin),
    .pixel_data      (pixel_data),
    .pixel_index     (pixel_index),
    .pixel_valid     (pixel_valid),
    .frame_done      (frame_done),
    .frame_error     (frame_error),
    .serial_data_out (sdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- DUT observation ----------------
  logic [23:0] got_data [0:255];
  logic [8:0]  got_idx  [0:255];
  int got_n = 0, fd_n = 0, fe_n = 0, both_n = 0;
  int fwd_phase = 2, fwd_bad = 0, fwd_ones1 = 0, sdo_ones = 0;
  logic [2:0] hist = '0;

  always @(negedge clk) begin
    if (pixel_valid && got_n < 256) begin
      got_data[got_n] <= pixel_data;
      got_idx[got_n]  <= pixel_index;
      got_n <= got_n + 1;
    end
    if (frame_done)                fd_n   <= fd_n + 1;
    if (frame_error)               fe_n   <= fe_n + 1;
    if (frame_done && frame_error) both_n <= both_n + 1;
    if (sdo === 1'b1)              sdo_ones <= sdo_ones + 1;
    if (fwd_phase == 0 && sdo !== 1'b0)    fwd_bad <= fwd_bad + 1;
    if (fwd_phase == 1 && sdo !== hist[2]) fwd_bad <= fwd_bad + 1;
    if (fwd_phase == 1 && sdo === 1'b1)    fwd_ones1 <= fwd_ones1 + 1;
    hist <= {hist[1:0], sin};
  end

  // ---------------- reference model ----------------
  bit          m_sync = 0;
  int          m_bits = 0, m_idx = 0, m_fd = 0, m_fe = 0;
  logic [23:0] m_word = '0;
  logic [23:0] exp_data [0:255];
  int          exp_idx  [0:255];
  int          exp_n = 0, rd = 0;

  task automatic model_clear();
    m_bits = 0;
    m_idx  = 0;
  endtask

  task automatic model_pulse(input int h, input int l);
    if (!m_sync) begin
      if (l >= RST_C) m_sync = 1;
    end else if (h < MINH || h > MAXH) begin
      m_fe++;
      m_sync = 0;
      model_clear();
      if (l >= RST_C) m_sync = 1;
    end else begin
      m_word = {m_word[22:0], (h >= THR) ? 1'b1 : 1'b0};
      m_bits++;
      if (m_bits == 24) begin
        if (m_idx < 512 && exp_n < 256) begin
          exp_data[exp_n] = m_word;
          exp_idx[exp_n]  = m_idx;
          exp_n++;
        end
        m_idx++;
        m_bits = 0;
      end
      if (l >= RST_C) begin
        m_fd++;
        if (m_bits != 0 || m_idx > 512) m_fe++;
        model_clear();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sin = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
    model_pulse(h, l);
  endtask

  task automatic lowgap(input int l);
    drive(1'b0, l);
    if (!m_sync && l >= RST_C) m_sync = 1;
  endtask

  task automatic send_pixel(input logic [23:0] w, input int h0, input int h1,
                            input int l, input int last_l);
    logic [23:0] wv;
    wv = w;
    for (int i = 23; i >= 0; i--)
      pulse(wv[i] ? h1 : h0, (i == 0) ? last_l : l);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_px_count"}, 64'(got_n), 64'(exp_n));
    for (int i = rd; i < exp_n; i++) begin
      if (i < got_n) begin
        check({tag, "_px_data"},  64'(got_data[i]), 64'(exp_data[i]));
        check({tag, "_px_index"}, 64'(got_idx[i]),  64'(exp_idx[i]));
      end
    end
    rd = exp_n;
    check({tag, "_frame_done"},  64'(fd_n), 64'(m_fd));
    check({tag, "_frame_error"}, 64'(fe_n), 64'(m_fe));
  endtask

  typedef struct {
    logic [23:0] word;
    int          h0;
    int          h1;
    logic [23:0] exp;
  } vec_t;

  vec_t tv [5];

  initial begin
    int g0, fd0, fe0, b0, ones;
    logic [23:0] w;

    tv[0] = '{24'hA5F00F, 4, 8,  24'hA5F00F};
    tv[1] = '{24'h5A5A5A, 5, 6,  24'h5A5A5A};
    tv[2] = '{24'hFFFFFF, 4, 5,  24'h000000};
    tv[3] = '{24'h000000, 6, 8,  24'hFFFFFF};
    tv[4] = '{24'h123456, 2, 20, 24'h123456};

    // reset state
    sin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({pixel_data, pixel_index, pixel_valid, frame_done, frame_error, sdo}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    lowgap(700);
    check("sync_no_strobes", 64'(fd_n + fe_n + got_n), 64'(0));

    // single-pixel frames from the table
    foreach (tv[k]) begin
      g0 = got_n; fd0 = fd_n; fe0 = fe_n;
      send_pixel(tv[k].word, tv[k].h0, tv[k].h1, 11, 700);
      check("tbl_px_count", 64'(got_n - g0), 64'(1));
      check("tbl_px_data",  64'(got_data[g0]), 64'(tv[k].exp));
      check("tbl_px_index", 64'(got_idx[g0]), 64'(0));
      check("tbl_frame_done",  64'(fd_n - fd0), 64'(1));
      check("tbl_frame_error", 64'(fe_n - fe0), 64'(0));
    end
    compare_model("tbl");

    // three pixels in one frame
    fd0 = fd_n;
    send_pixel(24'h000001, 4, 8, 11, 11);
    send_pixel(24'h800000, 4, 8, 11, 11);
    send_pixel(24'hFFFFFF, 4, 8, 11, 700);
    check("three_frame_done", 64'(fd_n - fd0), 64'(1));
    check("three_last_index", 64'(got_idx[got_n-1]), 64'(2));
    compare_model("three");

    // partial pixel: 10 bits then gap
    g0 = got_n; b0 = both_n;
    for (int i = 0; i < 10; i++) pulse((i % 2) ? 8 : 4, (i == 9) ? 700 : 11);
    check("partial_no_px", 64'(got_n - g0), 64'(0));
    check("partial_done_and_error", 64'(both_n - b0), 64'(1));
    send_pixel(24'hC3C3C3, 4, 8, 11, 700);
    check("partial_next_index", 64'(got_idx[got_n-1]), 64'(0));
    compare_model("partial");

    // 25-clock high, then a pixel that must be ignored until resync
    fe0 = fe_n; fd0 = fd_n;
    pulse(25, 11);
    check("long_high_error", 64'(fe_n - fe0), 64'(1));
    g0 = got_n;
    send_pixel(24'hFFFFFF, 4, 8, 11, 11);
    lowgap(700);
    check("long_high_ignored", 64'(got_n - g0), 64'(0));
    check("long_high_no_done", 64'(fd_n - fd0), 64'(0));
    send_pixel(24'h0F0F0F, 4, 8, 11, 700);
    compare_model("long");

    // 1-clock glitch mid-pixel
    fe0 = fe_n; fd0 = fd_n;
    pulse(4, 11); pulse(8, 11); pulse(4, 11);
    pulse(1, 700);
    check("glitch_error", 64'(fe_n - fe0), 64'(1));
    check("glitch_no_done", 64'(fd_n - fd0), 64'(0));
    send_pixel(24'h0000FF, 4, 8, 11, 700);
    compare_model("glitch");

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      int np;
      np = $urandom_range(3, 1);
      for (int p = 0; p < np; p++) begin
        for (int b = 0; b < 24; b++) begin
          int h, l;
          h = ($urandom_range(1, 0) == 1) ? $urandom_range(MAXH, THR) : $urandom_range(THR - 1, MINH);
          l = (p == np - 1 && b == 23) ? 700 : $urandom_range(40, 2);
          pulse(h, l);
        end
      end
    end
    compare_model("rand");

    // asynchronous reset after bit 12
    g0 = got_n;
    for (int i = 0; i < 11; i++) pulse(8, 11);
    drive(1'b1, 8);
    drive(1'b0, 3);
    rst_n = 1'b0;
    m_sync = 0;
    model_clear();
    @(negedge clk);
    check("rst_mid_outputs", 64'({pixel_data, pixel_index, pixel_valid, frame_done, frame_error, sdo}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs_hold", 64'({pixel_data, pixel_index, pixel_valid, frame_done, frame_error, sdo}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse(8, 11);
    lowgap(700);
    check("rst_no_strobe", 64'(got_n - g0), 64'(0));
    send_pixel(24'h3C00FF, 4, 8, 11, 700);
    compare_model("reset");

`ifdef XX6812_FORWARD_EN
    fwd_phase = 0;
    send_pixel(24'hDEAD01, 4, 8, 11, 11);
    fwd_phase = 1;
    w = 24'h96C3A5;
    ones = 0;
    for (int i = 0; i < 24; i++) ones += w[i] ? 8 : 4;
    send_pixel(w, 4, 8, 11, 700);
    fwd_phase = 2;
    check("fwd_replay_mismatches", 64'(fwd_bad), 64'(0));
    check("fwd_high_cycles", 64'(fwd_ones1), 64'(ones));
    compare_model("fwd");
`else
    w = 24'h96C3A5;
    send_pixel(24'hDEAD01, 4, 8, 11, 11);
    send_pixel(w, 4, 8, 11, 700);
    check("sdo_tied_low", 64'(sdo_ones), 64'(0));
    compare_model("nofwd");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
